// File: rtl/serial_add_sub_pkg.sv
// Shared definitions for the digit-serial adder/subtractor: FSM state encoding,
// operation codes and the carry/borrow-in helper.
package serial_add_sub_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Subtraction is a + ~b + 1, so a borrow-in of 1 must remove that implicit +1.
    function automatic logic init_carry(input logic cin, input logic op);
        return (op == OP_SUB) ? ~cin : cin;
    endfunction

endpackage

// File: rtl/serial_add_sub_full_adder_cell.sv
// One-bit combinational full adder; the serial adder chains DIGIT of these per clock.
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_add_sub.sv
// Digit-serial WIDTH-bit adder/subtractor, DIGIT bits per clock, LSB first.
// Define SERIAL_ADD_OVF_EN to add the registered signed-overflow output ovf.
module serial_add_sub #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic             ovf
`endif
);

    import serial_add_sub_pkg::*;

    localparam int STEPS = WIDTH / DIGIT;
    localparam int CW    = $clog2(STEPS) + 1;
    localparam logic [CW-1:0] LAST_COUNT = CW'(STEPS - 1);

    generate
        if ((DIGIT < 1) || (DIGIT > WIDTH) || ((WIDTH % DIGIT) != 0)) begin : g_bad_params
            $error("serial_add_sub: WIDTH must be a non-zero multiple of DIGIT");
        end
    endgenerate

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  op_a_q, op_a_d;
    logic [WIDTH-1:0]  op_b_q, op_b_d;
    logic [WIDTH-1:0]  res_q, res_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic [CW-1:0]     count_q, count_d;
    logic              carry_q, carry_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              cout_q, cout_d;
`ifdef SERIAL_ADD_OVF_EN
    logic              ovf_q, ovf_d;
`endif

    logic [DIGIT:0]         chain_c;
    logic [DIGIT-1:0]       digit_sum;
    logic [WIDTH+DIGIT-1:0] res_cat;

    assign chain_c[0] = carry_q;

    generate
        for (genvar i = 0; i < DIGIT; i++) begin : g_cell
            full_adder_cell u_cell (
                .a  (op_a_q[i]),
                .b  (op_b_q[i]),
                .ci (chain_c[i]),
                .s  (digit_sum[i]),
                .co (chain_c[i+1])
            );
        end
    endgenerate

    // New digits enter at the MSB end so the LSB-first result lands in place after STEPS shifts.
    assign res_cat = {digit_sum, res_q};

    always_comb begin
        state_d = state_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        res_d   = res_q;
        sum_d   = sum_q;
        count_d = count_q;
        carry_d = carry_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        cout_d  = cout_q;
`ifdef SERIAL_ADD_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    op_a_d  = a;
                    op_b_d  = (sub == OP_ADD) ? b : ~b;
                    carry_d = init_carry(cin, sub);
                    count_d = '0;
                    busy_d  = 1'b1;
                end
            end
            ST_RUN: begin
                res_d   = res_cat[WIDTH+DIGIT-1:DIGIT];
                op_a_d  = op_a_q >> DIGIT;
                op_b_d  = op_b_q >> DIGIT;
                carry_d = chain_c[DIGIT];
                count_d = count_q + CW'(1);
                if (count_q == LAST_COUNT) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    sum_d   = res_cat[WIDTH+DIGIT-1:DIGIT];
                    cout_d  = chain_c[DIGIT];
`ifdef SERIAL_ADD_OVF_EN
                    ovf_d   = chain_c[DIGIT-1] ^ chain_c[DIGIT];
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            op_a_q  <= '0;
            op_b_q  <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            count_q <= '0;
            carry_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cout_q  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            count_q <= count_d;
            carry_q <= carry_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            cout_q  <= cout_d;
`ifdef SERIAL_ADD_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
`ifdef SERIAL_ADD_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule
